// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: round-robin sharing of one pipelined FPU between two requesters, with tag pipe routing results back.
// Optional per-requester saturating issue counters when FPU_ARB_STATS_EN is defined.
module fpu_issue_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 8,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [WIDTH-1:0] Req0Operand1,
  input  logic [WIDTH-1:0] Req0Operand2,
  input  logic [1:0]       Req0Operation,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [WIDTH-1:0] Req1Operand1,
  input  logic [WIDTH-1:0] Req1Operand2,
  input  logic [1:0]       Req1Operation,
  output logic [WIDTH-1:0] FpuOperand1,
  output logic [WIDTH-1:0] FpuOperand2,
  output logic [1:0]       FpuOperation,
  input  logic [WIDTH-1:0] FpuResult,
  output logic             Rsp0Valid,
  output logic             Rsp1Valid,
`ifdef FPU_ARB_STATS_EN
  output logic [CNT_W-1:0] IssueCount0,
  output logic [CNT_W-1:0] IssueCount1,
`endif
  output logic [WIDTH-1:0] RspResult
);
  logic               ptr_q, ptr_d;
  logic               gnt, gnt_id;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [1:0]         opc_q, opc_d;
  logic [LATENCY-1:0] tv_q, ti_q;

  // With both requesting, ptr names the winner; otherwise the lone requester wins.
  always_comb begin
    gnt       = Req0Valid | Req1Valid;
    gnt_id    = (Req0Valid & Req1Valid) ? ptr_q : Req1Valid;
    Req0Ready = gnt & ~gnt_id;
    Req1Ready = gnt & gnt_id;
    ptr_d     = gnt ? ~gnt_id : ptr_q;
    op1_d     = !gnt ? op1_q : gnt_id ? Req1Operand1 : Req0Operand1;
    op2_d     = !gnt ? op2_q : gnt_id ? Req1Operand2 : Req0Operand2;
    opc_d     = !gnt ? opc_q : gnt_id ? Req1Operation : Req0Operation;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= 1'b0;
      op1_q <= '0;
      op2_q <= '0;
      opc_q <= '0;
      tv_q  <= '0;
      ti_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      opc_q <= opc_d;
      for (int i = LATENCY - 1; i > 0; i--) begin
        tv_q[i] <= tv_q[i-1];
        ti_q[i] <= ti_q[i-1];
      end
      tv_q[0] <= gnt;
      ti_q[0] <= gnt_id;
    end
  end

  assign FpuOperand1  = op1_q;
  assign FpuOperand2  = op2_q;
  assign FpuOperation = opc_q;
  assign Rsp0Valid    = tv_q[LATENCY-1] & ~ti_q[LATENCY-1];
  assign Rsp1Valid    = tv_q[LATENCY-1] & ti_q[LATENCY-1];
  assign RspResult    = FpuResult;

`ifdef FPU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = (Req0Ready && ~&cnt0_q) ? cnt0_q + 1'b1 : cnt0_q;
    cnt1_d = (Req1Ready && ~&cnt1_q) ? cnt1_q + 1'b1 : cnt1_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign IssueCount0 = cnt0_q;
  assign IssueCount1 = cnt1_q;
`endif
endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb_fpu_issue_arbiter: directed tables, corner sequences and random traffic against a queue-based scoreboard.
module tb_fpu_issue_arbiter;
  localparam int W  = 32;
  localparam int L  = 8;
  localparam int CW = 4;

  logic          CLK = 0, RST_N = 0;
  logic          Req0Valid, Req0Ready, Req1Valid, Req1Ready;
  logic [W-1:0]  Req0Operand1, Req0Operand2, Req1Operand1, Req1Operand2;
  logic [1:0]    Req0Operation, Req1Operation, FpuOperation;
  logic [W-1:0]  FpuOperand1, FpuOperand2, FpuResult, RspResult;
  logic          Rsp0Valid, Rsp1Valid;
`ifdef FPU_ARB_STATS_EN
  logic [CW-1:0] IssueCount0, IssueCount1;
`endif

  fpu_issue_arbiter #(.WIDTH(W), .LATENCY(L), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Operand1(Req0Operand1),
    .Req0Operand2(Req0Operand2), .Req0Operation(Req0Operation),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Operand1(Req1Operand1),
    .Req1Operand2(Req1Operand2), .Req1Operation(Req1Operation),
    .FpuOperand1(FpuOperand1), .FpuOperand2(FpuOperand2), .FpuOperation(FpuOperation),
    .FpuResult(FpuResult), .Rsp0Valid(Rsp0Valid), .Rsp1Valid(Rsp1Valid),
`ifdef FPU_ARB_STATS_EN
    .IssueCount0(IssueCount0), .IssueCount1(IssueCount1),
`endif
    .RspResult(RspResult)
  );

  always #5 CLK = ~CLK;

  // Toy FPU: op 2 treats 1.0 (3F800000) as the multiplicative identity.
  function automatic logic [W-1:0] fpu_f(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? ((a == 32'h3F800000) ? b : a * b) : a ^ b;
  endfunction

  // Result emerges L edges after the edge that changed the FPU inputs (that edge included).
  logic [W-1:0] fpipe [L-1];
  always @(posedge CLK) begin
    fpipe[0] <= fpu_f(FpuOperation, FpuOperand1, FpuOperand2);
    for (int i = 1; i < L - 1; i++) fpipe[i] <= fpipe[i-1];
  end
  assign FpuResult = fpipe[L-2];

  typedef struct { logic id; logic [W-1:0] res; int due; } txn_t;
  typedef struct { logic v0, v1, r0, r1; } vec_t;
  txn_t q[$];
  vec_t tbl[8];
  int   checks = 0, errors = 0, cyc = 0;
  int   gnts[2], rsps[2], stat[2];
  logic mptr = 0, exp_en = 0, exp_r0, exp_r1;

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  task automatic tick(input logic v0, input logic v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [1:0] o0, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] o1);
    logic g, id, e0, e1;
    Req0Valid = v0; Req0Operand1 = a0; Req0Operand2 = b0; Req0Operation = o0;
    Req1Valid = v1; Req1Operand1 = a1; Req1Operand2 = b1; Req1Operation = o1;
    @(negedge CLK);
    g  = v0 | v1;
    id = (v0 & v1) ? mptr : v1;
    chk("ready0", Req0Ready, g & !id);
    chk("ready1", Req1Ready, g & id);
    if (exp_en) begin
      chk("tbl_ready0", Req0Ready, exp_r0);
      chk("tbl_ready1", Req1Ready, exp_r1);
    end
    e0 = q.size() > 0 && q[0].due == cyc && !q[0].id;
    e1 = q.size() > 0 && q[0].due == cyc && q[0].id;
    chk("rsp0", Rsp0Valid, e0);
    chk("rsp1", Rsp1Valid, e1);
    rsps[0] += Rsp0Valid; rsps[1] += Rsp1Valid;
    if (e0 | e1) begin
      chk("result", RspResult, q[0].res);
      void'(q.pop_front());
    end
    if (g) begin
      q.push_back('{id, id ? fpu_f(o1, a1, b1) : fpu_f(o0, a0, b0), cyc + L});
      mptr = ~id;
      gnts[id]++;
      stat[id]++;
    end
    cyc++;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2 RST_N = 0;
    #1;
    chk("rst_op1", FpuOperand1, 0);
    chk("rst_op2", FpuOperand2, 0);
    chk("rst_opc", FpuOperation, 0);
    chk("rst_rsp", {Rsp0Valid, Rsp1Valid}, 0);
    Req0Valid = 0; Req1Valid = 0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    cyc += 2;
    q.delete();
    mptr = 0;
    stat[0] = 0; stat[1] = 0;
  endtask

  initial begin
    logic [W-1:0] a0, b0, a1, b1;
    int r0, r1;
    tbl = '{'{1,1,1,0}, '{1,1,0,1}, '{0,1,0,1}, '{1,1,1,0},
            '{0,0,0,0}, '{1,1,0,1}, '{1,0,1,0}, '{1,1,0,1}};
    Req0Valid = 0; Req1Valid = 0;
    Req0Operand1 = 0; Req0Operand2 = 0; Req0Operation = 0;
    Req1Operand1 = 0; Req1Operand2 = 0; Req1Operation = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("init_op1", FpuOperand1, 0);
    chk("init_rsp", {Rsp0Valid, Rsp1Valid}, 0);
    RST_N = 1;

    exp_en = 1;
    foreach (tbl[i]) begin
      exp_r0 = tbl[i].r0; exp_r1 = tbl[i].r1;
      tick(tbl[i].v0, tbl[i].v1, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom));
    end
    exp_en = 0;
    idle(L + 2);

    r0 = rsps[0];
    tick(1, 0, 32'h3F800000, 32'h40000000, 2'd2, 0, 0, 0);
    idle(L + 3);
    chk("single_rsp0_cnt", rsps[0] - r0, 1);
    chk("idle_hold_op1", FpuOperand1, 32'h3F800000);
    chk("idle_hold_op2", FpuOperand2, 32'h40000000);

    do_reset();
    gnts[0] = 0; gnts[1] = 0;
    for (int i = 0; i < 10; i++) tick(1, 1, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom));
    chk("cont_g0", gnts[0], 5);
    chk("cont_g1", gnts[1], 5);
    idle(L + 2);

    r1 = rsps[1];
    for (int i = 0; i < 20; i++) tick(0, 1, 0, 0, 0, $urandom, $urandom, 2'($urandom));
    idle(L + 2);
    chk("b2b_rsp1_cnt", rsps[1] - r1, 20);

    for (int i = 0; i < 5; i++) tick(1, 1, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom));
    do_reset();
    r0 = rsps[0]; r1 = rsps[1];
    idle(L + 2);
    chk("rst_discard", (rsps[0] - r0) + (rsps[1] - r1), 0);

    for (int i = 0; i < 20; i++) tick(1, 0, $urandom, $urandom, 2'($urandom), 0, 0, 0);
`ifdef FPU_ARB_STATS_EN
    chk("stat_sat0", IssueCount0, stat[0] > 15 ? 15 : stat[0]);
    chk("stat_cnt1", IssueCount1, stat[1] > 15 ? 15 : stat[1]);
`endif
    idle(L + 2);

    for (int i = 0; i < 400; i++) begin
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      tick(1'($urandom), 1'($urandom), a0, b0, 2'($urandom), a1, b1, 2'($urandom));
    end
    idle(L + 2);
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
